iter_divider: RTL and testbench



---
 rtl/iter_divider_pkg.sv | 20 ++
 rtl/iter_divider_div_step.sv | 34 +++
 rtl/iter_divider.sv | 133 +++++++++++++
 tb/tb_iter_divider.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/iter_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iter_divider_pkg
//  Description : Shared types for the iterative divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package iter_divider_pkg;

    typedef logic        i1;
    typedef logic [31:0] i32;
    typedef logic [63:0] i64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage : iter_divider_pkg
`default_nettype wire

// File: rtl/iter_divider_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational radix-2 restoring division step.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step
    import iter_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH-1:0] w_trial;
    i1                w_neg;

    assign w_shifted = {rem_i, quo_i[WIDTH-1]};

    // Sign of the (WIDTH+1)-bit trial subtraction taken as a compare; when the
    // trial is non-negative it is always below b, so WIDTH bits hold it exactly.
    assign w_neg   = (w_shifted < {1'b0, b_i});
    assign w_trial = w_shifted[WIDTH-1:0] - b_i;

    assign rem_o = w_neg ? w_shifted[WIDTH-1:0] : w_trial;
    assign quo_o = {quo_i[WIDTH-2:0], ~w_neg};

endmodule : div_step
`default_nettype wire

// File: rtl/iter_divider.sv
`default_nettype none
// ============================================================================
//  Module      : iter_divider
//  Description : Iterative unsigned restoring divider, valid/done handshake,
//                result c = {remainder, quotient}.
//  Revision    : 1.0 - initial release
// ============================================================================
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] c
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_t         state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    i1                  done_q, done_d;
    logic [2*WIDTH-1:0] c_q, c_d;

    logic [WIDTH-1:0]   w_step_rem;
    logic [WIDTH-1:0]   w_step_quo;
    i1                  w_start;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .b_i   (b_q),
        .rem_o (w_step_rem),
        .quo_o (w_step_quo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        c_d     = c_q;
        w_start = 1'b0;

        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (valid) begin
                    w_start = 1'b1;
                end
            end
            BUSY: begin
                done_d = 1'b0;
                if (!valid) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    rem_d = w_step_rem;
                    quo_d = w_step_quo;
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    // All WIDTH steps are in; this cycle registers the result.
                    state_d = DONE;
                    done_d  = 1'b1;
                    c_d     = {rem_q, quo_q};
                end
            end
            DONE: begin
                if (!valid) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end else if ((a != a_q) || (b != b_q)) begin
                    w_start = 1'b1;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                done_d  = 1'b0;
            end
        endcase

        if (w_start) begin
            state_d = BUSY;
            a_d     = a;
            b_d     = b;
            rem_d   = '0;
            quo_d   = a;
            cnt_d   = CNT_LOAD;
        end
    end

    assign done = done_q;
    assign c    = c_q;

endmodule : iter_divider
`default_nettype wire

// File: tb/tb_iter_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iter_divider
//  Description : Self-checking bench for iter_divider (directed table,
//                handshake corner sequences, randomized operands).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_divider;

    localparam int W       = 32;
    localparam int LATENCY = W + 1;

    logic          clk;
    logic          reset;
    logic          valid;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          done;
    logic [2*W-1:0] c;

    int checks = 0;
    int errors = 0;

    iter_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .valid (valid),
        .a     (a),
        .b     (b),
        .done  (done),
        .c     (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp_c;
    } vec_t;

    function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] x, input logic [W-1:0] y);
        if (y == '0) return {x, {W{1'b1}}};
        return {x % y, x / y};
    endfunction

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs must already be applied; the next edge is the start/restart edge.
    task automatic wait_done(input string name, input logic [2*W-1:0] exp);
        int  lat;
        bit  got;
        got = 1'b0;
        lat = 0;
        for (int n = 1; n <= LATENCY + 8; n++) begin
            tick();
            if (done) begin
                got = 1'b1;
                lat = n - 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: done never rose within %0d cycles", name, LATENCY + 8);
        end else begin
            chk({name, " latency"}, 64'(lat), 64'(LATENCY));
            chk({name, " result"}, c, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
        a     = x;
        b     = y;
        valid = 1'b1;
    endtask

    task automatic drop_valid();
        valid = 1'b0;
        tick();
    endtask

    vec_t vecs[10];

    initial begin
        logic [W-1:0]   ra, rb;
        logic [2*W-1:0] held;
        bit             saw_done;

        vecs[0] = '{32'd100,        32'd7,          64'h0000_0002_0000_000E};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF};
        vecs[2] = '{32'd5,          32'd0,          64'h0000_0005_FFFF_FFFF};
        vecs[3] = '{32'd9,          32'd3,          64'h0000_0000_0000_0003};
        vecs[4] = '{32'd50,         32'd8,          64'h0000_0002_0000_0006};
        vecs[5] = '{32'd0,          32'd5,          64'h0000_0000_0000_0000};
        vecs[6] = '{32'd7,          32'd7,          64'h0000_0000_0000_0001};
        vecs[7] = '{32'd3,          32'd10,         64'h0000_0003_0000_0000};
        vecs[8] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001};
        vecs[9] = '{32'h8000_0000,  32'd3,          64'h0000_0002_2AAA_AAAA};

        reset = 1'b1;
        valid = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        chk("reset done", 64'(done), 64'd0);
        chk("reset c", c, 64'd0);
        reset = 1'b0;
        tick();

        // Directed table, each from IDLE.
        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), vecs[i].exp_c);
            drop_valid();
            chk($sformatf("vec%0d idle done", i), 64'(done), 64'd0);
            chk($sformatf("vec%0d idle c kept", i), c, vecs[i].exp_c);
        end

        // done held while valid stays high with the same operands.
        start_op(32'd100, 32'd7);
        wait_done("hold", 64'h0000_0002_0000_000E);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("hold done %0d", k), 64'(done), 64'd1);
            chk($sformatf("hold c %0d", k), c, 64'h0000_0002_0000_000E);
        end

        // Back-to-back: new operands straight out of DONE.
        start_op(32'd9, 32'd3);
        wait_done("b2b", 64'h0000_0000_0000_0003);
        drop_valid();

        // Abort in BUSY cycle 10, then a fresh request.
        start_op(32'd1000, 32'd3);
        tick();
        for (int k = 0; k < 10; k++) tick();
        valid = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < LATENCY + 8; k++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        chk("abort no done", 64'(saw_done), 64'd0);
        chk("abort c kept", c, 64'h0000_0000_0000_0003);
        start_op(32'd50, 32'd8);
        wait_done("after abort", 64'h0000_0002_0000_0006);
        drop_valid();

        // Operands wander during BUSY; only the latched pair counts.
        start_op(32'd100, 32'd7);
        tick();
        for (int k = 0; k < 5; k++) tick();
        a = 32'hDEAD_BEEF;
        b = 32'd13;
        for (int k = 0; k < 10; k++) tick();
        a = 32'd100;
        b = 32'd7;
        saw_done = 1'b0;
        for (int k = 0; k < 30 && !saw_done; k++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        chk("wander done", 64'(saw_done), 64'd1);
        chk("wander c", c, 64'h0000_0002_0000_000E);
        drop_valid();

        // Asynchronous reset between edges while BUSY.
        start_op(32'd1234567, 32'd89);
        tick();
        for (int k = 0; k < 5; k++) tick();
        held = c;
        chk("pre-reset c nonzero", 64'(held != '0), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset done", 64'(done), 64'd0);
        chk("async reset c", c, 64'd0);
        tick();
        chk("reset held c", c, 64'd0);
        reset = 1'b0;
        wait_done("after reset", ref_div(32'd1234567, 32'd89));
        drop_valid();

        // Randomized pairs against the arithmetic model.
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 5))
                0: begin ra = $urandom; rb = '0; end
                1: begin
                    ra = $urandom;
                    if (ra == 32'hFFFF_FFFF) ra = ra - 32'd1;
                    rb = $urandom_range(32'hFFFF_FFFF, ra + 32'd1);
                end
                2: begin ra = $urandom; rb = ra; end
                3: begin ra = $urandom; rb = $urandom_range(255, 1); end
                default: begin ra = $urandom; rb = $urandom >> $urandom_range(31, 0); end
            endcase
            start_op(ra, rb);
            wait_done($sformatf("rand%0d a=%h b=%h", i, ra, rb), ref_div(ra, rb));
            drop_valid();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_iter_divider
`default_nettype wire
